// File: rtl/spm_mem_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port SPM memory arbiter.
interface spm_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt, done, rdata, busy, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt, done, rdata, busy, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/spm_mem_arbiter.sv
// Shares the single-port SPM memory between CPU (port 0) and loader (port 1).
// Define SPM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module spm_mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    spm_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          win_q, win_d;
    logic          last_q, last_d;
    logic          wr_q, wr_d;
    logic          win_sel;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;

`ifdef SPM_ARB_FIXED_PRIO_EN
    assign win_sel = ~bus.req[0];
`else
    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign win_sel = (bus.req == 2'b11) ? ~last_q : bus.req[1];
`endif

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    win_d       = win_sel;
                    wr_d        = bus.we[win_sel];
                    mem_addr_d  = win_sel ? bus.addr1 : bus.addr0;
                    mem_wdata_d = win_sel ? bus.wdata1 : bus.wdata0;
                    mem_we_d    = bus.we[win_sel];
                    gnt_d       = {win_sel, ~win_sel};
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    done_d  = {win_q, ~win_q};
                    state_d = S_DONE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = bus.mem_rdata;
                    done_d  = {win_q, ~win_q};
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                last_d  = win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            win_q       <= 1'b0;
            last_q      <= 1'b1;
            wr_q        <= 1'b0;
            cnt_q       <= 3'd0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_spm_mem_arbiter.sv
// Bench for spm_mem_arbiter: table vectors, hand sequences and a randomized transaction model.
module tb_spm_mem_arbiter;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

`ifdef SPM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    spm_mem_arbiter_if #(.AW(8), .DW(8)) ifA ();
    spm_mem_arbiter_if #(.AW(8), .DW(8)) ifB ();

    spm_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    spm_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(3)) dutB (.clk(clk), .rst(rst), .bus(ifB));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: unwritten locations read as addr ^ 8'h5A; read data delayed by the latency.
    logic [7:0] memA [256];
    bit         wrA  [256];
    logic [7:0] pipeA;
    logic [7:0] memB [256];
    bit         wrB  [256];
    logic [7:0] pipeB [3];

    function automatic logic [7:0] rdA(input logic [7:0] a);
        return wrA[a] ? memA[a] : (a ^ 8'h5A);
    endfunction
    function automatic logic [7:0] rdB(input logic [7:0] a);
        return wrB[a] ? memB[a] : (a ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (ifA.mem_we) begin
            memA[ifA.mem_addr] <= ifA.mem_wdata;
            wrA[ifA.mem_addr]  <= 1'b1;
        end
        pipeA <= rdA(ifA.mem_addr);
        if (ifB.mem_we) begin
            memB[ifB.mem_addr] <= ifB.mem_wdata;
            wrB[ifB.mem_addr]  <= 1'b1;
        end
        pipeB[0] <= rdB(ifB.mem_addr);
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign ifA.mem_rdata = pipeA;
    assign ifB.mem_rdata = pipeB[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Properties that must hold on every cycle for both instances.
    always @(negedge clk) begin
        chk("invA.gnt_onehot",  32'($onehot0(ifA.gnt)), 1);
        chk("invA.done_onehot", 32'($onehot0(ifA.done)), 1);
        chk("invA.gnt_and_done", 32'((|ifA.gnt) & (|ifA.done)), 0);
        chk("invA.we_outside_issue", 32'(ifA.mem_we & ~(|ifA.gnt)), 0);
        chk("invA.activity_not_busy", 32'(((|ifA.gnt) | (|ifA.done)) & ~ifA.busy), 0);
        chk("invB.gnt_onehot",  32'($onehot0(ifB.gnt)), 1);
        chk("invB.done_onehot", 32'($onehot0(ifB.done)), 1);
        chk("invB.gnt_and_done", 32'((|ifB.gnt) & (|ifB.done)), 0);
        chk("invB.we_outside_issue", 32'(ifB.mem_we & ~(|ifB.gnt)), 0);
    end

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [7:0] a0, a1, d0, d1;
        logic [1:0] gnt;
        logic [7:0] addr, wdata;
        logic       mw;
        int         dcyc;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl [10];

    // Called at a falling edge with port A idle; returns at the idle cycle after done.
    task automatic run_txn(input logic [1:0] req, input logic [1:0] we,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [1:0] egnt, input logic [7:0] eaddr,
                           input logic [7:0] ewdata, input logic emw, input int dcyc,
                           input logic [7:0] erdata, input string tag);
        ifA.req = req; ifA.we = we; ifA.addr0 = a0; ifA.addr1 = a1;
        ifA.wdata0 = d0; ifA.wdata1 = d1;
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(ifA.gnt), 32'(egnt));
        chk({tag, ".mem_addr"}, 32'(ifA.mem_addr), 32'(eaddr));
        chk({tag, ".mem_we"}, 32'(ifA.mem_we), 32'(emw));
        chk({tag, ".busy1"}, 32'(ifA.busy), 1);
        if (emw) chk({tag, ".mem_wdata"}, 32'(ifA.mem_wdata), 32'(ewdata));
        ifA.req = 2'b00;
        for (int c = 2; c <= dcyc; c++) begin
            @(negedge clk);
            chk({tag, ".gnt_after"}, 32'(ifA.gnt), 0);
            chk({tag, ".mem_we_after"}, 32'(ifA.mem_we), 0);
            chk({tag, ".busy"}, 32'(ifA.busy), 1);
            chk({tag, ".addr_held"}, 32'(ifA.mem_addr), 32'(eaddr));
            if (c < dcyc) begin
                chk({tag, ".done_early"}, 32'(ifA.done), 0);
            end else begin
                chk({tag, ".done"}, 32'(ifA.done), 32'(egnt));
                chk({tag, ".rdata"}, 32'(ifA.rdata), 32'(erdata));
            end
        end
        @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(ifA.busy), 0);
        chk({tag, ".idle_done"}, 32'(ifA.done), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] ref_mem [256];
    logic       m_last;
    logic [7:0] m_rdata;

    initial begin
        tbl[0] = '{2'b01, 2'b01, 8'h20, 8'h00, 8'hA5, 8'h00, 2'b01, 8'h20, 8'hA5, 1'b1, 2, 8'h4A};
        tbl[1] = '{2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10, 8'h20, 8'h00, 1'b0, 3, 8'hA5};
        tbl[2] = '{2'b11, 2'b00, 8'h30, 8'h40, 8'h00, 8'h00, 2'b01, 8'h30, 8'h00, 1'b0, 3, 8'h6A};
        tbl[3] = '{2'b11, 2'b00, 8'h31, 8'h41, 8'h00, 8'h00, 2'b10, 8'h41, 8'h00, 1'b0, 3, 8'h1B};
        tbl[4] = '{2'b11, 2'b01, 8'h41, 8'h50, 8'h3C, 8'h00, 2'b01, 8'h41, 8'h3C, 1'b1, 2, 8'h1B};
        tbl[5] = '{2'b11, 2'b10, 8'h60, 8'h77, 8'h00, 8'hC3, 2'b10, 8'h77, 8'hC3, 1'b1, 2, 8'h1B};
        tbl[6] = '{2'b01, 2'b00, 8'h41, 8'h00, 8'h00, 8'h00, 2'b01, 8'h41, 8'h00, 1'b0, 3, 8'h3C};
        tbl[7] = '{2'b10, 2'b00, 8'h00, 8'h77, 8'h00, 8'h00, 2'b10, 8'h77, 8'h00, 1'b0, 3, 8'hC3};
        tbl[8] = '{2'b11, 2'b11, 8'hFF, 8'hEE, 8'h00, 8'h11, 2'b01, 8'hFF, 8'h00, 1'b1, 2, 8'hC3};
        tbl[9] = '{2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 2'b01, 8'hFF, 8'h00, 1'b0, 3, 8'h00};

        rst = 1'b0;
        ifA.req = 2'b00; ifA.we = 2'b00; ifA.addr0 = '0; ifA.addr1 = '0;
        ifA.wdata0 = '0; ifA.wdata1 = '0;
        ifB.req = 2'b00; ifB.we = 2'b00; ifB.addr0 = '0; ifB.addr1 = '0;
        ifB.wdata0 = '0; ifB.wdata1 = '0;
        repeat (2) @(negedge clk);
        chk("rst.gnt", 32'(ifA.gnt), 0);
        chk("rst.done", 32'(ifA.done), 0);
        chk("rst.rdata", 32'(ifA.rdata), 0);
        chk("rst.busy", 32'(ifA.busy), 0);
        chk("rst.mem_addr", 32'(ifA.mem_addr), 0);
        chk("rst.mem_wdata", 32'(ifA.mem_wdata), 0);
        chk("rst.mem_we", 32'(ifA.mem_we), 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset asserted while a read sits in WAIT
        ifA.req = 2'b01; ifA.we = 2'b00; ifA.addr0 = 8'h10;
        @(negedge clk);
        chk("t1.gnt", 32'(ifA.gnt), 32'h1);
        ifA.req = 2'b00;
        @(negedge clk);
        chk("t1.busy_wait", 32'(ifA.busy), 1);
        #1 rst = 1'b0;
        #1;
        chk("t1.async_busy", 32'(ifA.busy), 0);
        chk("t1.async_mem_addr", 32'(ifA.mem_addr), 0);
        @(negedge clk);
        chk("t1.done_abandoned", 32'(ifA.done), 0);
        chk("t1.gnt", 32'(ifA.gnt), 0);
        chk("t1.busy", 32'(ifA.busy), 0);
        chk("t1.rdata", 32'(ifA.rdata), 0);
        chk("t1.mem_addr", 32'(ifA.mem_addr), 0);
        chk("t1.mem_wdata", 32'(ifA.mem_wdata), 0);
        chk("t1.mem_we", 32'(ifA.mem_we), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t1.post_done", 32'(ifA.done), 0);
        chk("t1.post_busy", 32'(ifA.busy), 0);
        run_txn(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 8'h10, 8'h00, 1'b0, 3, 8'h4A, "t1.read");

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
                    tbl[i].gnt, tbl[i].addr, tbl[i].wdata, tbl[i].mw, tbl[i].dcyc,
                    tbl[i].rdata, $sformatf("tbl%0d", i));
        end

        // Three-cycle latency instance: write then read back through port 1
        ifB.req = 2'b01; ifB.we = 2'b01; ifB.addr0 = 8'h20; ifB.wdata0 = 8'hA5;
        @(negedge clk);
        chk("t3.wr_gnt", 32'(ifB.gnt), 32'h1);
        chk("t3.wr_mem_we", 32'(ifB.mem_we), 1);
        chk("t3.wr_addr", 32'(ifB.mem_addr), 32'h20);
        chk("t3.wr_wdata", 32'(ifB.mem_wdata), 32'hA5);
        ifB.req = 2'b00;
        @(negedge clk);
        chk("t3.wr_done", 32'(ifB.done), 32'h1);
        chk("t3.wr_we_off", 32'(ifB.mem_we), 0);
        @(negedge clk);
        chk("t3.wr_idle", 32'(ifB.busy), 0);
        ifB.req = 2'b10; ifB.we = 2'b00; ifB.addr1 = 8'h20;
        @(negedge clk);
        chk("t3.rd_gnt", 32'(ifB.gnt), 32'h2);
        chk("t3.rd_mem_we", 32'(ifB.mem_we), 0);
        ifB.req = 2'b00;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t3.rd_done_c%0d", c), 32'(ifB.done), (c == 5) ? 32'h2 : 32'h0);
            chk($sformatf("t3.rd_busy_c%0d", c), 32'(ifB.busy), 1);
        end
        chk("t3.rd_rdata", 32'(ifB.rdata), 32'hA5);
        @(negedge clk);
        chk("t3.rd_idle", 32'(ifB.busy), 0);

        // Port 1 requests while port 0 is being served
        ifA.req = 2'b01; ifA.we = 2'b00; ifA.addr0 = 8'h12;
        @(negedge clk);
        chk("t5.gnt0", 32'(ifA.gnt), 32'h1);
        ifA.req = 2'b10; ifA.addr1 = 8'h13;
        @(negedge clk);
        chk("t5.no_gnt_c2", 32'(ifA.gnt), 0);
        @(negedge clk);
        chk("t5.no_gnt_c3", 32'(ifA.gnt), 0);
        chk("t5.done0", 32'(ifA.done), 32'h1);
        @(negedge clk);
        chk("t5.no_gnt_c4", 32'(ifA.gnt), 0);
        chk("t5.idle_c4", 32'(ifA.busy), 0);
        @(negedge clk);
        chk("t5.gnt1", 32'(ifA.gnt), 32'h2);
        chk("t5.addr1", 32'(ifA.mem_addr), 32'h13);
        ifA.req = 2'b00;
        repeat (2) @(negedge clk);
        chk("t5.done1", 32'(ifA.done), 32'h2);
        chk("t5.rdata1", 32'(ifA.rdata), 32'h49);
        @(negedge clk);
        ifA.req = 2'b01; ifA.addr0 = 8'h14;
        @(negedge clk);
        chk("t5.pulse_gnt0", 32'(ifA.gnt), 32'h1);
        ifA.req = 2'b10;
        @(negedge clk);
        ifA.req = 2'b00;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("t5.pulse_no_gnt_c%0d", c), 32'(ifA.gnt), 0);
            if (c == 3) chk("t5.pulse_done", 32'(ifA.done), 32'h1);
        end
        chk("t5.pulse_rdata", 32'(ifA.rdata), 32'h4E);
        chk("t5.pulse_idle", 32'(ifA.busy), 0);

        // Both ports hold req continuously
        do_reset();
        begin
            int n;
            n = 0;
            ifA.req = 2'b11; ifA.we = 2'b00; ifA.addr0 = 8'h05; ifA.addr1 = 8'h06;
            for (int c = 0; c < 40 && n < 6; c++) begin
                @(negedge clk);
                if (ifA.gnt != 2'b00) begin
                    chk($sformatf("t4.gnt%0d", n), 32'(ifA.gnt),
                        (FIXED || (n % 2 == 0)) ? 32'h1 : 32'h2);
                    n++;
                end
            end
            chk("t4.grant_count", 32'(n), 6);
            ifA.req = 2'b00;
            repeat (3) @(negedge clk);
            chk("t4.idle", 32'(ifA.busy), 0);
        end

        // Randomized transactions against the reference model
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        m_last  = 1'b1;
        m_rdata = 8'h00;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] r, w;
            logic [7:0] a0, a1, d0, d1, ea, erd;
            logic       win, iswr;
            r  = 2'($urandom_range(1, 3));
            w  = 2'($urandom_range(0, 3));
            a0 = 8'h80 | 8'($urandom_range(0, 15));
            a1 = 8'h80 | 8'($urandom_range(0, 15));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            if (r == 2'b11) win = FIXED ? 1'b0 : (m_last == 1'b0);
            else            win = (r == 2'b10);
            ea   = win ? a1 : a0;
            iswr = w[win];
            if (iswr) begin
                ref_mem[ea] = win ? d1 : d0;
                erd = m_rdata;
            end else begin
                erd = ref_mem[ea];
            end
            run_txn(r, w, a0, a1, d0, d1, win ? 2'b10 : 2'b01, ea, win ? d1 : d0, iswr,
                    iswr ? 2 : 3, erd, $sformatf("rnd%0d", i));
            m_rdata = erd;
            m_last  = win;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
